// File: rtl/car_sensor_driver.sv
// rtl/car_sensor_driver.sv - emulated outer/inner photo-sensor waveform generator for one car pass
// Optional statistics counters n_enter/n_exit are enabled by defining TRAFFIC_STATS_EN.
module car_sensor_driver #(
   parameter int DWELL_W = 16,
   parameter int STAT_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               dir,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               abort,
   output logic               ready,
   output logic               busy,
   output logic               outer,
   output logic               inner,
   output logic               done,
   output logic               aborted
`ifdef TRAFFIC_STATS_EN
   ,
   output logic [STAT_W-1:0]  n_enter,
   output logic [STAT_W-1:0]  n_exit
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_B2, S_B1} state_t;

   state_t             state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               dir_q, dir_d;
   logic [1:0]         oi_q, oi_d;
   logic               done_q, done_d;
   logic               aborted_q, aborted_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic [DWELL_W-1:0] dwell_eff;
   logic [DWELL_W-1:0] reload;

   // {outer,inner} for a state; exit mirrors enter, back-out states reuse P2/P1 patterns
   function automatic logic [1:0] pattern(input state_t s, input logic d);
      case (s)
         S_P1, S_B1: pattern = d ? 2'b01 : 2'b10;
         S_P2, S_B2: pattern = 2'b11;
         S_P3:       pattern = d ? 2'b10 : 2'b01;
         default:    pattern = 2'b00;
      endcase
   endfunction

   assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign reload    = dwell_q - DWELL_W'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dwell_d   = dwell_q;
      dir_d     = dir_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dir_d   = dir;
               dwell_d = dwell_eff;
               cnt_d   = dwell_eff - DWELL_W'(1);
               state_d = S_P1;
            end
         end
         S_P1: begin
            if (abort) begin
               state_d   = S_IDLE;
               cnt_d     = '0;
               aborted_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = S_P2;
               cnt_d   = reload;
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         S_P2: begin
            if (abort) begin
               state_d = S_B1;
               cnt_d   = reload;
            end else if (cnt_q == '0) begin
               state_d = S_P3;
               cnt_d   = reload;
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         S_P3: begin
            if (abort) begin
               state_d = S_B2;
               cnt_d   = reload;
            end else if (cnt_q == '0) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         S_B2: begin
            if (cnt_q == '0) begin
               state_d = S_B1;
               cnt_d   = reload;
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         S_B1: begin
            if (cnt_q == '0) begin
               state_d   = S_IDLE;
               cnt_d     = '0;
               aborted_d = 1'b1;
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Outputs are computed from the next state so they can be registered
      oi_d    = pattern(state_d, dir_d);
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         dwell_q   <= '0;
         dir_q     <= 1'b0;
         oi_q      <= 2'b00;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dwell_q   <= dwell_d;
         dir_q     <= dir_d;
         oi_q      <= oi_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   assign outer   = oi_q[1];
   assign inner   = oi_q[0];
   assign done    = done_q;
   assign aborted = aborted_q;
   assign ready   = ready_q;
   assign busy    = busy_q;

`ifdef TRAFFIC_STATS_EN
   logic [STAT_W-1:0] n_enter_q, n_exit_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_enter_q <= '0;
         n_exit_q  <= '0;
      end else if (done_d) begin
         if (dir_q) n_exit_q  <= n_exit_q + STAT_W'(1);
         else       n_enter_q <= n_enter_q + STAT_W'(1);
      end
   end

   assign n_enter = n_enter_q;
   assign n_exit  = n_exit_q;
`endif

endmodule

// File: tb/tb_car_sensor_driver.sv
// tb/tb_car_sensor_driver.sv - randomized bench for car_sensor_driver against a queue-based waveform model
module tb_car_sensor_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       dir = 1'b0;
   logic [3:0] dwell = 4'd0;
   logic       abort = 1'b0;
   logic       ready, busy, outer, inner, done, aborted;
`ifdef TRAFFIC_STATS_EN
   logic [7:0] n_enter, n_exit;
`endif

   int checks = 0;
   int errors = 0;

   car_sensor_driver #(.DWELL_W(4), .STAT_W(8)) dut (
      .clk(clk), .reset(rst), .start(start), .dir(dir), .dwell(dwell), .abort(abort),
      .ready(ready), .busy(busy), .outer(outer), .inner(inner), .done(done), .aborted(aborted)
`ifdef TRAFFIC_STATS_EN
      , .n_enter(n_enter), .n_exit(n_exit)
`endif
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model: every future cycle of the current car is a queue entry; idle is the empty queue
   typedef struct packed {
      logic [1:0] oi;
      logic       dn;
      logic       ab;
      logic       rdy;
      logic [2:0] ph;
   } ent_t;

   localparam ent_t IDLE_E = '{oi: 2'b00, dn: 1'b0, ab: 1'b0, rdy: 1'b1, ph: 3'd0};

   ent_t q[$];
   ent_t cur = IDLE_E;
   logic m_dir = 1'b0;
   int   m_de = 1;
   int   m_enter = 0;
   int   m_exit = 0;

   function automatic logic [1:0] pat(input int ph, input logic d);
      if (ph == 2) return 2'b11;
      if (ph == 1) return d ? 2'b01 : 2'b10;
      return d ? 2'b10 : 2'b01;
   endfunction

   task automatic push_n(input logic [1:0] oi, input int ph, input int n);
      ent_t e;
      for (int k = 0; k < n; k++) begin
         e = '{oi: oi, dn: 1'b0, ab: 1'b0, rdy: 1'b0, ph: 3'(ph)};
         q.push_back(e);
      end
   endtask

   initial begin
      ent_t e;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete();
            cur = IDLE_E;
            m_enter = 0;
            m_exit = 0;
         end else begin
            if (cur.rdy) begin
               if (start) begin
                  m_de = (dwell == 0) ? 1 : int'(dwell);
                  m_dir = dir;
                  q.delete();
                  for (int p = 1; p <= 3; p++) push_n(pat(p, m_dir), p, m_de);
                  e = '{oi: 2'b00, dn: 1'b1, ab: 1'b0, rdy: 1'b1, ph: 3'd0};
                  q.push_back(e);
               end
            end else if (abort && cur.ph <= 3) begin
               q.delete();
               if (cur.ph >= 3) push_n(2'b11, 4, m_de);
               if (cur.ph >= 2) push_n(pat(1, m_dir), 5, m_de);
               e = '{oi: 2'b00, dn: 1'b0, ab: 1'b1, rdy: 1'b1, ph: 3'd0};
               q.push_back(e);
            end
            cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
            if (cur.dn) begin
               if (m_dir) m_exit = (m_exit + 1) % 256;
               else       m_enter = (m_enter + 1) % 256;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("outputs{o,i,done,ab,rdy,busy}", {outer, inner, done, aborted, ready, busy},
             {cur.oi, cur.dn, cur.ab, cur.rdy, ~cur.rdy});
`ifdef TRAFFIC_STATS_EN
         chk("n_enter", n_enter, m_enter);
         chk("n_exit", n_exit, m_exit);
`endif
      end
   end

   logic [1:0] lit;

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_ready", ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_oi", {outer, inner}, 0);
      chk("reset_pulses", {done, aborted}, 0);
      rst = 1'b0;

      // Enter, dwell 3: 10 x3, 11 x3, 01 x3, then 00 with done at cycle 10
      start = 1'b1; dir = 1'b0; dwell = 4'd3;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         lit = (c <= 3) ? 2'b10 : (c <= 6) ? 2'b11 : (c <= 9) ? 2'b01 : 2'b00;
         chk("lit_enter_oi", {outer, inner}, lit);
         chk("lit_enter_done", done, (c == 10) ? 1 : 0);
         chk("lit_enter_busy", busy, (c <= 9) ? 1 : 0);
         if (c < 10) @(negedge clk);
      end

      // Enter, dwell 2, abort on 2nd cycle of 01: 11 x2, 10 x2, then 00 aborted
      start = 1'b1; dwell = 4'd2;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         lit = (c <= 2) ? 2'b10 : (c <= 4) ? 2'b11 : (c <= 6) ? 2'b01 :
               (c <= 8) ? 2'b11 : (c <= 10) ? 2'b10 : 2'b00;
         chk("lit_abort_oi", {outer, inner}, lit);
         chk("lit_abort_pulses", {done, aborted}, (c == 11) ? 1 : 0);
         abort = (c == 6);
         @(negedge clk);
      end
      abort = 1'b0;

      // Exit, dwell 0 treated as 1: 01, 11, 10, then done
      start = 1'b1; dir = 1'b1; dwell = 4'd0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         lit = (c == 1) ? 2'b01 : (c == 2) ? 2'b11 : (c == 3) ? 2'b10 : 2'b00;
         chk("lit_exit0_oi", {outer, inner}, lit);
         chk("lit_exit0_done", done, (c == 4) ? 1 : 0);
         @(negedge clk);
      end

      // Asynchronous reset in the 11 phase clears outputs before the next edge
      start = 1'b1; dir = 1'b0; dwell = 4'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_oi", {outer, inner}, 0);
      chk("async_rst_ready", ready, 1);
      chk("async_rst_pulses", {done, aborted}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Start held high: back-to-back cars with one idle cycle between them
      start = 1'b1; dir = 1'b0; dwell = 4'd1;
      repeat (40) @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);

      // Full-range dwell including all-ones
      start = 1'b1; dir = 1'b1; dwell = 4'hF;
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);

      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         dir = 1'($urandom);
         dwell = 4'($urandom_range(0, 15));
         abort = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      abort = 1'b0;

`ifdef TRAFFIC_STATS_EN
      start = 1'b1; dir = 1'b0; dwell = 4'd0;
      repeat (1100) @(negedge clk);
`endif

      start = 1'b0;
      repeat (60) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
